// File: rtl/mem_c_deskew_pkg.sv
// Shared sizing and lane-vector type for the systolic matmul memories
// (A/B input skew, C output de-skew) and the array itself.
package mem_c_deskew_pkg;

  localparam int unsigned DIM     = 8;
  localparam int unsigned BITS_AB = 8;
  localparam int unsigned BITS_C  = 16;

  typedef logic signed [DIM-1:0][BITS_C-1:0] c_row_t;

endpackage

// File: rtl/mem_c_lane.sv
// One de-skew lane: a signed shift register of fixed depth that shifts
// every cycle, cleared by async reset or synchronous clr.
module mem_c_lane
  import mem_c_deskew_pkg::*;
#(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned BITS_C = mem_c_deskew_pkg::BITS_C
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic signed [BITS_C-1:0] d,
  output logic signed [BITS_C-1:0] q
);

  logic signed [BITS_C-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/mem_c_deskew.sv
// Output de-skew buffer: realigns the staggered result lanes of the systolic
// array into one row vector with a valid strobe, row counter and tile-end flag.
module mem_c_deskew
  import mem_c_deskew_pkg::*;
#(
  parameter int unsigned DIM    = mem_c_deskew_pkg::DIM,
  parameter int unsigned BITS_C = mem_c_deskew_pkg::BITS_C
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              en,
  input  logic signed [DIM-1:0][BITS_C-1:0] Cin,
  output logic signed [DIM-1:0][BITS_C-1:0] Cout,
  output logic                              vld,
  output logic                              last,
  output logic [$clog2(DIM)-1:0]            row_cnt
);

  localparam int unsigned CW = $clog2(DIM);

  logic [DIM-1:0] vpipe;

  // Lane j sees its data j cycles late, so it needs DIM-j stages to line up.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    mem_c_lane #(
      .DEPTH  (DIM - j),
      .BITS_C (BITS_C)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .d     (Cin[j]),
      .q     (Cout[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vpipe <= '0;
    else if (clr) vpipe <= '0;
    else          vpipe <= {vpipe[DIM-2:0], en};
  end

  assign vld = vpipe[DIM-1];

  // clr takes priority over a row leaving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   row_cnt <= '0;
    else if (clr) row_cnt <= '0;
    else if (vld) row_cnt <= (row_cnt == CW'(DIM - 1)) ? '0 : row_cnt + 1'b1;
  end

  assign last = vld && (row_cnt == CW'(DIM - 1));

endmodule

// File: doc/mem_c_deskew.md
# mem_c_deskew

Output de-skew buffer for the systolic matrix-multiply datapath: the mirror of the B-side input skew memory. The array emits result rows staggered one cycle per column: lane j of a row arrives j cycles after lane 0. This block delays each lane so that all DIM lanes of a row leave together on one aligned vector with a single valid strobe. It also counts emitted rows and flags the last row of a DIM×DIM result tile.

## Interface
- DIM, 8: number of lanes (array width) and rows per tile
- BITS_C, 16: signed result width per lane
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of pipeline and row counter
- en  in  1  row-start strobe: lane 0 of a new row is on Cin[0] this cycle
- Cin  in  signed [BITS_C-1:0] [DIM-1:0]  skewed array outputs
- Cout  out  signed [BITS_C-1:0] [DIM-1:0]  aligned row
- vld  out  1  Cout holds a complete aligned row
- last  out  1  with vld: this row is row DIM-1 of the tile
- row_cnt  out  $clog2(DIM)  rows emitted since reset/clr, modulo DIM

## Operation
- Lane j is a shift register of depth DIM-j; it shifts every cycle, with no enable gating.
- en enters a valid pipe of depth DIM; vld is the pipe output.
- Row r with en sampled at edge E:
  - Lane j data is sampled at edge E+j.
  - All lanes are visible on Cout after edge E+DIM-1.
- Data passes unmodified: no arithmetic, no sign extension, full BITS_C width.
- Cout is don't-care when vld=0, but it is deterministic: stale shifted data, or zero after reset/clr.
- Row counter:
  - increments on each cycle with vld=1;
  - wraps DIM-1 → 0;
  - last = vld && (row_cnt == DIM-1), combinational from registered state.
- Rows may be back-to-back (en every cycle) or gapped arbitrarily; in-flight rows never interact.
- The upstream array guarantees Cin[j] holds row r data exactly j cycles after en. The block does not check this.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): all lane registers = 0, valid pipe = 0, row_cnt = 0. Hence Cout = 0, vld = 0, last = 0.
- Latency: en high in cycle t → vld high in cycle t+DIM, for exactly one cycle per en.
- Throughput: one row per cycle.
- clr:
  - On the next edge, all lane registers, the valid pipe and row_cnt go to 0.
  - en sampled in the same cycle as clr is discarded.
  - Every in-flight row is dropped; vld stays 0 for DIM cycles unless new en arrives after clr.
- clr and vld in the same cycle: the outgoing row is still presented in that cycle, but row_cnt does not increment (clr wins).
- Reset mid-operation: immediate async clear with the same values as above. No partial rows emerge afterwards.
- Row_cnt wrap: the cycle after last, row_cnt = 0; last falls unless another tile continues.

## Structure
- A shared package holds DIM, BITS_AB, BITS_C and the lane vector typedef, shared with the B/A memories and the array.
- One sub-module, mem_c_lane: parameters DEPTH and BITS_C. It is a signed shift register with async reset and sync clr, and the top instantiates it in a generate loop with DEPTH = DIM-j.
- The valid pipe and row counter sit in the top.

## Test plan
All scenarios use DIM=8, BITS_C=16.
- Reset: hold rst_n=0 while driving random Cin and en=1 → Cout all 0, vld=0, last=0, row_cnt=0. Release → first vld no earlier than 8 cycles after the first sampled en.
- Single row: en at cycle 0, Cin[j]=j+1 driven in cycle j → in cycle 8 vld=1, Cout={1,2,…,8}; vld=0 in cycles 7 and 9.
- Full tile back-to-back: en in cycles 0–7, row r lane j = 16·r+j → vld in cycles 8–15 with the correct aligned rows. last=1 only in cycle 15, row_cnt=0 in cycle 16.
- Gapped rows and extremes: rows at cycles 0, 3 and 4 with lane values alternating -32768/32767 → vld exactly in cycles 8, 11 and 12, with values bit-exact.
- clr mid-flight: rows at cycles 0 and 1, clr in cycle 4 → no vld in cycles 8–9, row_cnt=0. A new row at cycle 6 emerges in cycle 14.
- Async reset mid-flight: rst_n low for 2 ns mid-cycle 5 after rows at 0–3 → outputs zero immediately, with no vld afterwards.
